// File: rtl/ctrl.sv
// Viterbi datapath sequencer: per symbol it strobes branch-metric, ACS and
// survivor-write stages, then runs a fixed-length traceback once per frame.
module ctrl #(
  parameter int FRAME_LEN = 4,
  parameter int TB_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic en_brch,
  output logic en_add,
  output logic en_mem,
  output logic en_tbck
);

  localparam int SYM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TB_W  = (TB_LEN > 1) ? $clog2(TB_LEN) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(FRAME_LEN - 1);
  localparam logic [TB_W-1:0]  TB_LAST  = TB_W'(TB_LEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BRCH = 3'd1,
    ADD  = 3'd2,
    MEM  = 3'd3,
    TBCK = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [TB_W-1:0]  tb_cnt_q, tb_cnt_d;
  logic             en_brch_q, en_brch_d;
  logic             en_add_q, en_add_d;
  logic             en_mem_q, en_mem_d;
  logic             en_tbck_q, en_tbck_d;

  // Strobes are the registered one-hot decode of the state being entered,
  // so a paused cycle (en=0) forces every strobe low while state holds.
  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    tb_cnt_d  = tb_cnt_q;
    en_brch_d = 1'b0;
    en_add_d  = 1'b0;
    en_mem_d  = 1'b0;
    en_tbck_d = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: state_d = BRCH;
        BRCH: state_d = ADD;
        ADD:  state_d = MEM;
        MEM: begin
          if (sym_cnt_q == SYM_LAST) begin
            state_d   = TBCK;
            sym_cnt_d = '0;
            tb_cnt_d  = '0;
          end else begin
            state_d   = BRCH;
            sym_cnt_d = sym_cnt_q + SYM_W'(1);
          end
        end
        TBCK: begin
          if (tb_cnt_q == TB_LAST) begin
            state_d  = IDLE;
            tb_cnt_d = '0;
          end else begin
            tb_cnt_d = tb_cnt_q + TB_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      en_brch_d = (state_d == BRCH);
      en_add_d  = (state_d == ADD);
      en_mem_d  = (state_d == MEM);
      en_tbck_d = (state_d == TBCK);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      tb_cnt_q  <= '0;
      en_brch_q <= 1'b0;
      en_add_q  <= 1'b0;
      en_mem_q  <= 1'b0;
      en_tbck_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      tb_cnt_q  <= tb_cnt_d;
      en_brch_q <= en_brch_d;
      en_add_q  <= en_add_d;
      en_mem_q  <= en_mem_d;
      en_tbck_q <= en_tbck_d;
    end
  end

  assign en_brch = en_brch_q;
  assign en_add  = en_add_q;
  assign en_mem  = en_mem_q;
  assign en_tbck = en_tbck_q;

endmodule

// File: tb/tb_ctrl.sv
// Bench for ctrl: default-parameter and FRAME_LEN=1/TB_LEN=1 instances share
// stimulus; each is compared with a frame-schedule model every cycle.
module tb_ctrl;

  localparam int FL_A = 4;
  localparam int TL_A = 4;
  localparam int FL_B = 1;
  localparam int TL_B = 1;
  localparam int P_A  = 3 * FL_A + TL_A + 1;
  localparam int P_B  = 3 * FL_B + TL_B + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic a_brch, a_add, a_mem, a_tbck;
  logic b_brch, b_add, b_mem, b_tbck;

  int checks = 0;
  int errors = 0;

  // Model: position within the frame schedule; the last slot is the idle gap.
  int ptr_a = P_A - 1;
  int ptr_b = P_B - 1;
  logic [3:0] exp_a, exp_b;

  always #5 clk = ~clk;

  ctrl #(.FRAME_LEN(FL_A), .TB_LEN(TL_A)) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .en_brch(a_brch), .en_add(a_add), .en_mem(a_mem), .en_tbck(a_tbck)
  );

  ctrl #(.FRAME_LEN(FL_B), .TB_LEN(TL_B)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .en_brch(b_brch), .en_add(b_add), .en_mem(b_mem), .en_tbck(b_tbck)
  );

  // {brch, add, mem, tbck} expected at a given schedule slot
  function automatic logic [3:0] slot_out(int ptr, int f, int t);
    if (ptr < 3 * f) begin
      case (ptr % 3)
        0:       return 4'b1000;
        1:       return 4'b0100;
        default: return 4'b0010;
      endcase
    end else if (ptr < 3 * f + t) begin
      return 4'b0001;
    end
    return 4'b0000;
  endfunction

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step(logic r, logic e);
    logic [3:0] oa, ob;
    rst = r;
    en  = e;
    @(posedge clk);
    if (r) begin
      ptr_a = P_A - 1;
      ptr_b = P_B - 1;
      exp_a = 4'b0000;
      exp_b = 4'b0000;
    end else if (!e) begin
      exp_a = 4'b0000;
      exp_b = 4'b0000;
    end else begin
      ptr_a = (ptr_a + 1) % P_A;
      ptr_b = (ptr_b + 1) % P_B;
      exp_a = slot_out(ptr_a, FL_A, TL_A);
      exp_b = slot_out(ptr_b, FL_B, TL_B);
    end
    #1;
    oa = {a_brch, a_add, a_mem, a_tbck};
    ob = {b_brch, b_add, b_mem, b_tbck};
    check("dflt_out", oa, exp_a);
    check("corner_out", ob, exp_b);
    checks++;
    assert ($countones(oa) <= 1 && $countones(ob) <= 1) else begin
      errors++;
      $error("FAIL onehot observed=%b/%b expected=at_most_one", oa, ob);
    end
  endtask

  initial begin
    exp_a = 4'b0000;
    exp_b = 4'b0000;
    // reset held with en low and high, then released with en low
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    // basic frame plus restart of the next frame
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1);
    // fresh frame, pause 3 cycles after the 2nd en_add
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    // remaining symbols, then two traceback cycles, pause 2 cycles in traceback
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    // run into the next traceback and reset in the middle of it
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    // randomized run/pause with occasional reset
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 75));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl.md
Name: ctrl

Overview:
Sequencing controller for the Viterbi decoder datapath. For each frame it steps through the branch-metric, add-compare-select and survivor-memory-write phases once per received symbol. After the last symbol of the frame it runs a fixed-length traceback phase. It drives one enable strobe per datapath stage, and at most one strobe is high in any cycle.

Parameters:
- FRAME_LEN, default 4: symbols per frame. Legal range ≥1.
- TB_LEN, default 4: traceback cycles per frame. Legal range ≥1.

Ports:
- clk: input, 1 bit. Single clock; all state is updated on the rising edge.
- rst: input, 1 bit. Synchronous, active-high reset.
- en: input, 1 bit. Run/pause control. High lets the FSM advance; low freezes it.
- en_brch: output, 1 bit. Branch-metric unit enable.
- en_add: output, 1 bit. Add-compare-select unit enable.
- en_mem: output, 1 bit. Survivor-memory write enable.
- en_tbck: output, 1 bit. Traceback unit enable.

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous and active-high.
- State register: states IDLE, BRCH, ADD, MEM, TBCK.
- Counters:
  - sym_cnt, width clog2(FRAME_LEN), minimum 1 bit.
  - tb_cnt, width clog2(TB_LEN), minimum 1 bit.
- All four outputs are registered, with no combinational path from en to any output.
- Reset (rst=1 at a posedge): state=IDLE, sym_cnt=0, tb_cnt=0, all outputs 0. Reset has priority over en and applies mid-frame; a reset frame is abandoned, not resumed.
- Pause (rst=0, en=0 at a posedge):
  - State and both counters hold.
  - All four outputs load 0.
  - When en returns high, the sequence resumes from the held state, so no phase is skipped or repeated.
- Run (rst=0, en=1 at a posedge): next-state transitions are:
  - IDLE → BRCH.
  - BRCH → ADD.
  - ADD → MEM.
  - MEM → TBCK with sym_cnt=0 and tb_cnt=0, if sym_cnt==FRAME_LEN-1.
  - MEM → BRCH with sym_cnt+1, otherwise.
  - TBCK → IDLE with tb_cnt=0, if tb_cnt==TB_LEN-1.
  - TBCK → TBCK with tb_cnt+1, otherwise.
- Output decode on a run edge: outputs load the one-hot decode of the next state.
  - BRCH→en_brch, ADD→en_add, MEM→en_mem, TBCK→en_tbck.
  - IDLE → all outputs 0.
- Output timing:
  - A strobe is high during the cycle following the edge that entered its state.
  - The first strobe appears one clock after the first edge sampling en=1.
- Frame period under continuous en=1: 3·FRAME_LEN + TB_LEN + 1 cycles, including one IDLE gap cycle between frames. With defaults this is 17 cycles: 12 symbol-phase cycles, 4 en_tbck cycles, 1 idle cycle.
- Invariant: en_brch+en_add+en_mem+en_tbck ≤ 1 in every cycle.
- Frames repeat automatically while en stays high. No external start/done handshake.

Test Plan:
1. Reset: hold rst=1 with en=0 or en=1 for 2 cycles → all outputs 0. Release rst with en=0 → outputs stay 0 indefinitely.
2. Basic frame (defaults): rst=0, then raise en and hold it, first run edge = edge 1.
   - Edges 1–12 give outputs brch, add, mem ×4.
   - Edges 13–16 give en_tbck.
   - Edge 17 gives all 0.
   - Edge 18 gives en_brch, restarting the frame.
3. Pause mid-frame: drop en for 3 cycles right after the en_add cycle of symbol 2 → outputs 0 for those 3 cycles. Re-raise en → next strobe is en_mem, and traceback still starts after exactly 4 en_mem pulses total.
4. Pause in traceback: drop en after the 2nd en_tbck cycle for 2 cycles, then restore → exactly 2 more en_tbck cycles, then the IDLE cycle.
5. Reset mid-traceback: assert rst for 1 cycle during en_tbck with en=1 → outputs 0. After release, a fresh frame runs: en_brch one edge later, then a full 4 symbols.
6. Parameter corners: FRAME_LEN=1, TB_LEN=1 → repeating pattern brch, add, mem, tbck, idle (period 5). Check the one-hot invariant every cycle in all scenarios.
